// File: rtl/wb_checkpoint_monitor.sv
// wb_checkpoint_monitor
//   Wishbone-slave progress monitor. Firmware posts signatures; the block checks them
//   against EXP_BASE, EXP_BASE+1, ... (mod 2^CHK_W), mirrors accepted values on the
//   check pins and raises pass/fail (mismatch or per-step timeout) with an irq pulse.
//
// Ports
//   wb_clk_i, resetb            clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i  Wishbone request (sel ignored, full-word access)
//   wbs_adr_i, wbs_dat_i        byte address, write data
//   wbs_ack_o, wbs_dat_o        acknowledge, read data
//   check_o, check_oeb          last accepted signature, pad output-enable (active low)
//   pass_o, fail_o, irq_o       run passed, run failed, one-cycle pulse on PASS/FAIL entry
//
// Register map (wbs_adr_i[4:2]): 0 CTRL, 1 SIG, 2 STATUS, 3 TIMEOUT, 4 EXP_BASE, 5 TRACE.
//
// Build option: define CKPT_TRACE_EN to add a 4-entry trace of SIG writes made in WAIT,
// popped by TRACE reads. Without it TRACE reads 0.

module wb_checkpoint_monitor #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int unsigned CHK_W       = 16,
   parameter int unsigned NUM_STEPS   = 2,
   parameter logic [15:0] START_SIG   = 16'hAB60,
   parameter logic [31:0] TIMEOUT_RST = 32'd30000
) (
   input  logic             wb_clk_i,
   input  logic             resetb,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   output logic [CHK_W-1:0] check_o,
   output logic [CHK_W-1:0] check_oeb,
   output logic             pass_o,
   output logic             fail_o,
   output logic             irq_o
);

   typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StPass = 2'd2, StFail = 2'd3} state_e;

   state_e           state_q;
   logic [7:0]       step_q;
   logic [31:0]      timer_q;
   logic [31:0]      tmo_reg_q;
   logic [CHK_W-1:0] exp_base_q;
   logic [CHK_W-1:0] check_q;
   logic [CHK_W-1:0] oeb_q;
   logic [CHK_W-1:0] last_sig_q;
   logic             pass_q, fail_q, irq_q, timeout_q, mismatch_q;
   logic             ack_q;
   logic [31:0]      dat_q;

   logic             req, hit, wr, rd;
   logic [2:0]       idx;
   logic             wr_ctrl, wr_sig, wr_tmo, wr_exp, rd_trace;
   logic [CHK_W-1:0] sig, exp_sig;
   logic             last_step;
   logic [31:0]      rdata, trace_rdata;

   // The cycle after an ack never starts a new transfer.
   assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign hit = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
   assign idx = wbs_adr_i[4:2];
   assign wr  = req & wbs_we_i & hit;
   assign rd  = req & ~wbs_we_i & hit;

   assign wr_ctrl  = wr && (idx == 3'd0);
   assign wr_sig   = wr && (idx == 3'd1);
   assign wr_tmo   = wr && (idx == 3'd3);
   assign wr_exp   = wr && (idx == 3'd4);
   assign rd_trace = rd && (idx == 3'd5);

   assign sig       = wbs_dat_i[CHK_W-1:0];
   assign exp_sig   = exp_base_q + CHK_W'(step_q);
   assign last_step = (step_q == 8'(NUM_STEPS - 1));

`ifdef CKPT_TRACE_EN
   logic [CHK_W-1:0] trace_mem_q [4];
   logic [1:0]       trace_wr_q, trace_rd_q;
   logic [2:0]       trace_cnt_q;
   logic             trace_push, trace_pop, trace_flush, trace_full;

   assign trace_push  = wr_sig && (state_q == StWait);
   assign trace_pop   = rd_trace && (trace_cnt_q != 3'd0);
   assign trace_flush = wr_ctrl && (wbs_dat_i[1] || wbs_dat_i[0]);
   assign trace_full  = (trace_cnt_q == 3'd4);
   assign trace_rdata = (trace_cnt_q != 3'd0) ?
                        {1'b1, 15'b0, 16'(trace_mem_q[trace_rd_q])} : 32'b0;

   always_ff @(posedge wb_clk_i) begin
      if (!resetb || trace_flush) begin
         trace_wr_q  <= '0;
         trace_rd_q  <= '0;
         trace_cnt_q <= '0;
      end else begin
         if (trace_push) trace_wr_q <= trace_wr_q + 2'd1;
         // A push into a full trace overwrites the oldest entry, so the read side moves too.
         if (trace_pop || (trace_push && trace_full)) trace_rd_q <= trace_rd_q + 2'd1;
         if (trace_push && !trace_pop && !trace_full) trace_cnt_q <= trace_cnt_q + 3'd1;
         else if (trace_pop && !trace_push)           trace_cnt_q <= trace_cnt_q - 3'd1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (trace_push) trace_mem_q[trace_wr_q] <= sig;
   end
`else
   assign trace_rdata = 32'b0;
`endif

   logic unused_ok;
   assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], rd_trace};

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (idx)
            3'd2:    rdata = {16'(last_sig_q), step_q, 4'b0000, mismatch_q, timeout_q, state_q};
            3'd3:    rdata = tmo_reg_q;
            3'd4:    rdata = 32'(exp_base_q);
            3'd5:    rdata = trace_rdata;
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!resetb) begin
         state_q    <= StIdle;
         step_q     <= '0;
         timer_q    <= '0;
         tmo_reg_q  <= TIMEOUT_RST;
         exp_base_q <= CHK_W'(START_SIG);
         check_q    <= '0;
         oeb_q      <= '1;
         last_sig_q <= '0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         irq_q      <= 1'b0;
         timeout_q  <= 1'b0;
         mismatch_q <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
      end else begin
         ack_q <= req;
         dat_q <= (req && !wbs_we_i) ? rdata : 32'b0;
         irq_q <= 1'b0;
         if (wr_sig) last_sig_q <= sig;
         if (wr_tmo) tmo_reg_q <= wbs_dat_i;
         if (wr_exp) exp_base_q <= sig;

         if (wr_ctrl && wbs_dat_i[1]) begin
            state_q    <= StIdle;
            step_q     <= '0;
            timer_q    <= '0;
            check_q    <= '0;
            oeb_q      <= '1;
            last_sig_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
         end else if (wr_ctrl && wbs_dat_i[0]) begin
            state_q    <= StWait;
            step_q     <= '0;
            timer_q    <= tmo_reg_q;
            check_q    <= '0;
            oeb_q      <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
         end else if (state_q == StWait) begin
            if (wr_sig) begin
               // A commit on the expiry cycle wins over the timeout.
               if (sig == exp_sig) begin
                  check_q <= sig;
                  timer_q <= tmo_reg_q;
                  step_q  <= step_q + 8'd1;
                  if (last_step) begin
                     state_q <= StPass;
                     pass_q  <= 1'b1;
                     irq_q   <= 1'b1;
                  end
               end else begin
                  state_q    <= StFail;
                  fail_q     <= 1'b1;
                  mismatch_q <= 1'b1;
                  irq_q      <= 1'b1;
               end
            end else if (timer_q != 32'd0) begin
               // A zero timer never counts, which is how TIMEOUT=0 disables the check.
               timer_q <= timer_q - 32'd1;
               if (timer_q == 32'd1) begin
                  state_q   <= StFail;
                  fail_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  irq_q     <= 1'b1;
               end
            end
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign check_o   = check_q;
   assign check_oeb = oeb_q;
   assign pass_o    = pass_q;
   assign fail_o    = fail_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_checkpoint_monitor.sv
module tb_wb_checkpoint_monitor;

   localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef CKPT_TRACE_EN
   localparam int NSTEPS = 8;
`else
   localparam int NSTEPS = 2;
`endif

   logic        clk, resetb;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_i;
   logic        ack;
   logic [31:0] dat_o;
   logic [15:0] check, oeb;
   logic        pass, fail, irq;

   wb_checkpoint_monitor #(
      .BASE_ADDR  (BASE),
      .CHK_W      (16),
      .NUM_STEPS  (NSTEPS),
      .START_SIG  (16'hAB60),
      .TIMEOUT_RST(32'd30000)
   ) dut (
      .wb_clk_i (clk),
      .resetb   (resetb),
      .wbs_cyc_i(cyc),
      .wbs_stb_i(stb),
      .wbs_we_i (we),
      .wbs_sel_i(sel),
      .wbs_adr_i(adr),
      .wbs_dat_i(dat_i),
      .wbs_ack_o(ack),
      .wbs_dat_o(dat_o),
      .check_o  (check),
      .check_oeb(oeb),
      .pass_o   (pass),
      .fail_o   (fail),
      .irq_o    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc_n = 0;
   int     irq_cnt = 0;

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
      end
   endfunction

   // ---------------- behavioural model (transaction level, deadline arithmetic) ----------
   bit          m_valid = 0;
   logic        m_ack, m_pass, m_fail, m_irq, m_to, m_mm;
   logic [31:0] m_rdata, m_tmo;
   int          m_state;   // 0 idle, 1 wait, 2 pass, 3 fail
   int          m_step;
   logic [15:0] m_check, m_oeb, m_last, m_exp;
   longint      m_dl;
   bit          m_dl_on;
   logic [15:0] m_trace[$];

   function automatic void m_flags_clear();
      m_pass = 0; m_fail = 0; m_to = 0; m_mm = 0; m_step = 0; m_check = 16'h0;
      m_trace.delete();
   endfunction

   function automatic void m_set_deadline();
      m_dl_on = (m_tmo != 0);
      m_dl    = cyc_n + longint'(m_tmo);
   endfunction

   function automatic void m_reset();
      m_flags_clear();
      m_ack = 0; m_rdata = 0; m_irq = 0; m_state = 0; m_oeb = 16'hFFFF; m_last = 16'h0;
      m_tmo = 32'd30000; m_exp = 16'hAB60; m_dl_on = 0; m_dl = 0;
   endfunction

   function automatic void m_edge();
      logic        req, hit, handled;
      logic [2:0]  idx;
      logic [15:0] d16, e;
      logic [31:0] r;
      req = cyc && stb && !m_ack;
      hit = (adr[31:5] == BASE[31:5]);
      idx = adr[4:2];
      d16 = dat_i[15:0];
      m_irq = 0;
      handled = 0;
      r = 32'h0;
      if (req && !we && hit) begin
         case (idx)
            3'd2: r = {m_last, 8'(m_step), 4'h0, m_mm, m_to, 2'(m_state)};
            3'd3: r = m_tmo;
            3'd4: r = {16'h0, m_exp};
`ifdef CKPT_TRACE_EN
            3'd5: if (m_trace.size() > 0) begin
               r = {16'h8000, m_trace[0]};
               m_trace.delete(0);
            end
`endif
            default: r = 32'h0;
         endcase
      end
      if (req && we && hit) begin
         case (idx)
            3'd0: begin
               if (dat_i[1]) begin
                  m_flags_clear(); m_state = 0; m_oeb = 16'hFFFF; m_last = 16'h0; m_dl_on = 0;
                  handled = 1;
               end else if (dat_i[0]) begin
                  m_flags_clear(); m_state = 1; m_oeb = 16'h0; m_set_deadline();
                  handled = 1;
               end
            end
            3'd1: begin
               m_last = d16;
               if (m_state == 1) begin
                  handled = 1;
`ifdef CKPT_TRACE_EN
                  m_trace.push_back(d16);
                  if (m_trace.size() > 4) m_trace.delete(0);
`endif
                  e = m_exp + 16'(m_step);
                  if (d16 == e) begin
                     m_check = d16;
                     m_step++;
                     m_set_deadline();
                     if (m_step == NSTEPS) begin m_state = 2; m_pass = 1; m_irq = 1; end
                  end else begin
                     m_state = 3; m_fail = 1; m_mm = 1; m_irq = 1;
                  end
               end
            end
            3'd3: m_tmo = dat_i;
            3'd4: m_exp = d16;
            default: ;
         endcase
      end
      if (!handled && m_state == 1 && m_dl_on && cyc_n == m_dl) begin
         m_state = 3; m_fail = 1; m_to = 1; m_irq = 1;
      end
      m_ack   = req;
      m_rdata = r;
   endfunction

   always @(posedge clk) begin
      cyc_n++;
      if (!resetb) begin
         m_reset();
         m_valid = 1;
      end else if (m_valid) begin
         m_edge();
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("ack", {31'b0, ack}, {31'b0, m_ack});
         chk("check_o", {16'b0, check}, {16'b0, m_check});
         chk("check_oeb", {16'b0, oeb}, {16'b0, m_oeb});
         chk("pass_o", {31'b0, pass}, {31'b0, m_pass});
         chk("fail_o", {31'b0, fail}, {31'b0, m_fail});
         chk("irq_o", {31'b0, irq}, {31'b0, m_irq});
         if (m_ack) chk("dat_o", dat_o, m_rdata);
      end
      if (irq === 1'b1) irq_cnt++;
   end

   // ---------------- drivers ----------------
   task automatic wb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] r);
      int n;
      @(negedge clk);
      cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ack && n < 8);
      r = dat_o;
      if (!ack) chk("wb_ack_wait", {31'b0, ack}, 32'd1);
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wr(input logic [2:0] i, input logic [31:0] d);
      logic [31:0] r;
      wb(BASE | {27'b0, i, 2'b00}, 1'b1, d, r);
   endtask

   task automatic rdr(input logic [2:0] i, output logic [31:0] r);
      wb(BASE | {27'b0, i, 2'b00}, 1'b0, 32'h0, r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetb = 0; cyc = 0; stb = 0; we = 0;
      @(negedge clk);
      resetb = 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r, d;
      int n, acks, i0, op;
      cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = 0; dat_i = 0; resetb = 0;
      repeat (3) @(negedge clk);
      resetb = 1;
      #1;
      chk("rst_oeb", {16'b0, oeb}, 32'h0000_FFFF);
      chk("rst_check", {16'b0, check}, 32'h0);

      // Nominal run
      i0 = irq_cnt;
      wr(0, 32'h1);
      wr(1, 32'hAB60);
      chk("t1_check_first", {16'b0, check}, 32'hAB60);
      for (int i = 1; i < NSTEPS; i++) wr(1, 32'hAB60 + i);
      chk("t1_pass", {31'b0, pass}, 32'd1);
      chk("t1_check_last", {16'b0, check}, 32'hAB60 + NSTEPS - 1);
      rdr(2, r);
      chk("t1_status_state", {30'b0, r[1:0]}, 32'd2);
      chk("t1_irq_pulses", irq_cnt - i0, 32'd1);

      // Mismatch
      wr(0, 32'h1);
      wr(1, 32'hAB60);
      wr(1, 32'hAB62);
      chk("t2_fail", {31'b0, fail}, 32'd1);
      chk("t2_check_kept", {16'b0, check}, 32'hAB60);
      rdr(2, r);
      chk("t2_mismatch", {31'b0, r[3]}, 32'd1);
      chk("t2_last_sig", {16'b0, r[31:16]}, 32'hAB62);

      // Timeout latency, then disabled timeout
      wr(3, 32'd100);
      wr(0, 32'h1);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!fail && n < 200);
      chk("t3_fail_latency", n, 32'd100);
      rdr(2, r);
      chk("t3_timeout_flag", {31'b0, r[2]}, 32'd1);
      wr(3, 32'd0);
      wr(0, 32'h1);
      repeat (300) @(posedge clk);
      #1;
      chk("t3_no_timeout", {31'b0, fail}, 32'd0);

      // Wrap-around, then reset mid-WAIT
      wr(4, 32'hFFFF);
      wr(0, 32'h1);
      for (int i = 0; i < NSTEPS; i++) wr(1, 32'(16'(16'hFFFF + i)));
      chk("t4_wrap_pass", {31'b0, pass}, 32'd1);
      wr(0, 32'h1);
      wr(1, 32'hFFFF);
      do_reset();
      chk("t4_rst_check", {16'b0, check}, 32'h0);
      chk("t4_rst_oeb", {16'b0, oeb}, 32'h0000_FFFF);
      rdr(4, r);
      chk("t4_rst_exp_base", r, 32'h0000_AB60);

      // Commit on the expiry cycle wins; arm+clear goes idle
      wr(3, 32'd10);
      wr(0, 32'h1);
      repeat (9) @(posedge clk);
      wr(1, 32'hAB60);
      chk("t5_commit_wins", {31'b0, fail}, 32'd0);
      rdr(2, r);
      chk("t5_still_wait", {30'b0, r[1:0]}, 32'd1);
      wr(0, 32'h3);
      rdr(2, r);
      chk("t5_arm_clear_idle", {30'b0, r[1:0]}, 32'd0);

      // Held strobe: acks must alternate
      @(negedge clk);
      cyc = 1; stb = 1; we = 0; adr = BASE | 32'h8;
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      cyc = 0; stb = 0;
      chk("burst_acks", acks, 32'd2);

      // Trace
      wr(3, 32'd0);
      wr(0, 32'h1);
      for (int i = 0; i < 5; i++) wr(1, 32'hAB60 + i);
      for (int k = 0; k < 5; k++) begin
         rdr(5, r);
`ifdef CKPT_TRACE_EN
         chk("t6_trace_pop", r, (k < 4) ? (32'h8000_0000 | (32'hAB61 + k)) : 32'h0);
`else
         chk("t6_trace_zero", r, 32'h0);
`endif
      end

      // Randomized traffic against the model
      repeat (600) begin
         op = $urandom_range(0, 99);
         if (op < 10)      wr(0, 32'h1);
         else if (op < 14) wr(0, {30'b0, 2'($urandom_range(2, 3))});
         else if (op < 50) wr(1, {16'b0, 16'(m_exp + 16'(m_step))});
         else if (op < 60) wr(1, $urandom);
         else if (op < 66) wr(3, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 40));
         else if (op < 70) wr(4, $urandom);
         else if (op < 88) rdr(3'($urandom_range(0, 7)), r);
         else if (op < 90) do_reset();
         else if (op < 95) wr(3'($urandom_range(5, 7)), $urandom);
         else begin
            d = $urandom;
            wb(32'h2000_0000 | {27'b0, 3'($urandom_range(0, 7)), 2'b00}, 1'($urandom), d, r);
         end
         repeat ($urandom_range(0, 12)) @(posedge clk);
      end

      repeat (4) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
